// File: rtl/strobe_cdc_pkg.sv
// Shared definitions for the strobe CDC arbiter and its ack synchronizer.
package strobe_cdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_REL = 2'd2,
        ST_RECOVER  = 2'd3
    } state_e;

    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop level synchronizer for a single asynchronous bit.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/strobe_cdc_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack CDC channel between
// N_REQ strobe sources; pulses done per requester when its handshake closes.
module strobe_cdc_arbiter
    import strobe_cdc_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ID_W        = $clog2(N_REQ),
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] done_o,
    output logic             busy_o,
    output logic [N_REQ-1:0] pending_o,
    output logic             chan_req_o,
    output logic [ID_W-1:0]  chan_id_o,
    input  logic             chan_ack_i,
    output logic             err_timeout_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    // First set bit at or after ptr, wrapping at N_REQ (not at 2^ID_W).
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] pend,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] win;
        logic [ID_W:0]   idx;
        logic            found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
            if (!found && pend[idx]) begin
                found = 1'b1;
                win   = idx[ID_W-1:0];
            end
        end
        return win;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] res;
        for (int i = 0; i < N_REQ; i++) res[i] = (id == ID_W'(i));
        return res;
    endfunction

    state_e           state;
    logic [N_REQ-1:0] pend;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;
    logic             ack_s;
    logic             grant;
    logic [ID_W-1:0]  winner;
    logic [N_REQ-1:0] grant_mask;
    logic             timeout_hit;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (chan_ack_i),
        .q     (ack_s)
    );

    // A stale ack seen in IDLE blocks new grants until it drops.
    assign grant       = (state == ST_IDLE) && !ack_s && (|pend);
    assign winner      = rr_pick(pend, ptr);
    assign grant_mask  = grant ? onehot(winner) : '0;
    assign timeout_hit = (TIMEOUT_CYC > 0) && (cnt == CNT_LAST);

    // A strobe coinciding with its own grant re-arms the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= (pend & ~grant_mask) | req_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            chan_req_o    <= 1'b0;
            chan_id_o     <= '0;
            ptr           <= '0;
            cnt           <= '0;
            done_o        <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            done_o        <= '0;
            err_timeout_o <= 1'b0;
            cnt           <= cnt + CNT_W'(1);
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        chan_req_o <= 1'b1;
                        chan_id_o  <= winner;
                        ptr        <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
                        cnt        <= '0;
                        state      <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_s) begin
                        chan_req_o <= 1'b0;
                        cnt        <= '0;
                        state      <= ST_WAIT_REL;
                    end else if (timeout_hit) begin
                        chan_req_o    <= 1'b0;
                        err_timeout_o <= 1'b1;
                        cnt           <= '0;
                        state         <= ST_RECOVER;
                    end
                end
                ST_WAIT_REL: begin
                    if (!ack_s) begin
                        done_o <= onehot(chan_id_o);
                        state  <= ST_IDLE;
                    end else if (timeout_hit) begin
                        err_timeout_o <= 1'b1;
                        cnt           <= '0;
                        state         <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    if (!ack_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o    = (state != ST_IDLE);
    assign pending_o = pend;

endmodule
